id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the execute stage, with operand forwarding and load-use detection.

---
 rtl/id_ex_stage_pkg.sv | 38 +++
 rtl/id_ex_stage_if.sv | 59 +++++
 rtl/id_ex_stage_forward_unit.sv | 38 +++
 rtl/id_ex_stage.sv | 93 +++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, ALU/forwarding enums and the ID/EX entry record
package id_ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXM,
    FWD_MWB
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    alu_ctrl_t             alu_ctrl;
    logic                  alu_src;
    logic                  op1_pc;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } id_ex_entry_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, producer and execute-side signals of the ID/EX stage
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [XLEN-1:0]       in_imm;
  logic [XLEN-1:0]       in_pc;
  alu_ctrl_t             in_alu_ctrl;
  logic                  in_alu_src;
  logic                  in_op1_pc;
  logic                  in_uses_rs2;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  in_reg_write;

  logic [REG_ADDR_W-1:0] exm_rd;
  logic                  exm_reg_write;
  logic [XLEN-1:0]       exm_result;
  logic [REG_ADDR_W-1:0] mwb_rd;
  logic                  mwb_reg_write;
  logic [XLEN-1:0]       mwb_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_W-1:0]     alu_ctrl;
  logic [XLEN-1:0]       alu_op1;
  logic [XLEN-1:0]       alu_op2;
  logic [XLEN-1:0]       store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_pc;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_reg_write;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm, in_pc,
           in_alu_ctrl, in_alu_src, in_op1_pc, in_uses_rs2, in_mem_read, in_mem_write,
           in_reg_write, exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write,
           mwb_result, out_ready,
    input  in_ready, out_valid, alu_ctrl, alu_op1, alu_op2, store_data, out_rd, out_pc,
           out_mem_read, out_mem_write, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm, in_pc,
           in_alu_ctrl, in_alu_src, in_op1_pc, in_uses_rs2, in_mem_read, in_mem_write,
           in_reg_write, exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write,
           mwb_result, out_ready,
    output in_ready, out_valid, alu_ctrl, alu_op1, alu_op2, store_data, out_rd, out_pc,
           out_mem_read, out_mem_write, out_reg_write
  );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// rtl/id_ex_stage_forward_unit.sv - per-operand bypass select; EX/MEM beats MEM/WB, x0 reads zero
module id_ex_stage_forward_unit
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] r_i,
  input  logic [XLEN-1:0]       reg_data_i,
  input  logic [REG_ADDR_W-1:0] exm_rd_i,
  input  logic                  exm_reg_write_i,
  input  logic [XLEN-1:0]       exm_result_i,
  input  logic [REG_ADDR_W-1:0] mwb_rd_i,
  input  logic                  mwb_reg_write_i,
  input  logic [XLEN-1:0]       mwb_result_i,
  output fwd_sel_t              sel_o,
  output logic [XLEN-1:0]       value_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (r_i != '0) begin
      if (exm_reg_write_i && (exm_rd_i == r_i)) begin
        sel_o = FWD_EXM;
      end else if (mwb_reg_write_i && (mwb_rd_i == r_i)) begin
        sel_o = FWD_MWB;
      end
    end

    value_o = reg_data_i;
    case (sel_o)
      FWD_EXM: value_o = exm_result_i;
      FWD_MWB: value_o = mwb_result_i;
      default: value_o = reg_data_i;
    endcase
    if (r_i == '0) begin
      value_o = '0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubble
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic          clk_i,
  input logic          rst_ni,
  input logic          flush_i,
  id_ex_stage_if.slave io
);

  id_ex_entry_t    entry_q, entry_d;
  logic            valid_q, valid_d;
  logic            load_use;
  fwd_sel_t        fwd1_sel, fwd2_sel;
  logic [XLEN-1:0] fwd1_val, fwd2_val;

  id_ex_stage_forward_unit u_fwd1 (
    .r_i(entry_q.rs1), .reg_data_i(entry_q.rs1_data),
    .exm_rd_i(io.exm_rd), .exm_reg_write_i(io.exm_reg_write), .exm_result_i(io.exm_result),
    .mwb_rd_i(io.mwb_rd), .mwb_reg_write_i(io.mwb_reg_write), .mwb_result_i(io.mwb_result),
    .sel_o(fwd1_sel), .value_o(fwd1_val)
  );

  id_ex_stage_forward_unit u_fwd2 (
    .r_i(entry_q.rs2), .reg_data_i(entry_q.rs2_data),
    .exm_rd_i(io.exm_rd), .exm_reg_write_i(io.exm_reg_write), .exm_result_i(io.exm_result),
    .mwb_rd_i(io.mwb_rd), .mwb_reg_write_i(io.mwb_reg_write), .mwb_result_i(io.mwb_result),
    .sel_o(fwd2_sel), .value_o(fwd2_val)
  );

  assign load_use = valid_q & entry_q.mem_read & (entry_q.rd != '0) & io.in_valid &
                    ((io.in_rs1 == entry_q.rd) | (io.in_uses_rs2 & (io.in_rs2 == entry_q.rd)));

  assign io.in_ready = (~valid_q | io.out_ready) & ~load_use & ~flush_i;

  // A load-use stall with out_ready low falls into the hold branch; with out_ready high it bubbles.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (valid_q & ~io.out_ready) begin
      if (fwd1_sel != FWD_REG) entry_d.rs1_data = fwd1_val;
      if (fwd2_sel != FWD_REG) entry_d.rs2_data = fwd2_val;
    end else if (load_use) begin
      valid_d = 1'b0;
    end else if (io.in_valid) begin
      valid_d            = 1'b1;
      entry_d.rs1        = io.in_rs1;
      entry_d.rs2        = io.in_rs2;
      entry_d.rd         = io.in_rd;
      entry_d.rs1_data   = io.in_rs1_data;
      entry_d.rs2_data   = io.in_rs2_data;
      entry_d.imm        = io.in_imm;
      entry_d.pc         = io.in_pc;
      entry_d.alu_ctrl   = io.in_alu_ctrl;
      entry_d.alu_src    = io.in_alu_src;
      entry_d.op1_pc     = io.in_op1_pc;
      entry_d.mem_read   = io.in_mem_read;
      entry_d.mem_write  = io.in_mem_write;
      entry_d.reg_write  = io.in_reg_write;
    end else begin
      valid_d = 1'b0;
    end
    if (!valid_d) begin
      entry_d.mem_read  = 1'b0;
      entry_d.mem_write = 1'b0;
      entry_d.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign io.out_valid     = valid_q;
  assign io.alu_ctrl      = entry_q.alu_ctrl;
  assign io.alu_op1       = entry_q.op1_pc ? entry_q.pc : fwd1_val;
  assign io.alu_op2       = entry_q.alu_src ? entry_q.imm : fwd2_val;
  assign io.store_data    = fwd2_val;
  assign io.out_rd        = entry_q.rd;
  assign io.out_pc        = entry_q.pc;
  assign io.out_mem_read  = entry_q.mem_read;
  assign io.out_mem_write = entry_q.mem_write;
  assign io.out_reg_write = entry_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .io     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.in_valid      = 1'b0;
    bus.in_rs1        = '0;
    bus.in_rs2        = '0;
    bus.in_rd         = '0;
    bus.in_rs1_data   = '0;
    bus.in_rs2_data   = '0;
    bus.in_imm        = '0;
    bus.in_pc         = '0;
    bus.in_alu_ctrl   = ALU_ADD;
    bus.in_alu_src    = 1'b0;
    bus.in_op1_pc     = 1'b0;
    bus.in_uses_rs2   = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_mem_write  = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.exm_rd        = '0;
    bus.exm_reg_write = 1'b0;
    bus.exm_result    = '0;
    bus.mwb_rd        = '0;
    bus.mwb_reg_write = 1'b0;
    bus.mwb_result    = '0;
    bus.out_ready     = 1'b1;
    flush             = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_in();

    // Reset with an instruction offered
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rs1 = 5'd9;  bus.in_rs1_data = 32'hDEAD;
    bus.in_pc = 32'h40; bus.in_op1_pc = 1'b1; bus.in_reg_write = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_alu_op1", bus.alu_op1, 32'd0);
    chk("rst_alu_op2", bus.alu_op2, 32'd0);
    chk("rst_store_data", bus.store_data, 32'd0);
    chk("rst_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd0);
    chk("rst_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    clear_in();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Forward priority on rs1
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd5; bus.in_rs1_data = 32'h99;
    tick();
    chk("fwd_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("fwd_none", bus.alu_op1, 32'h99);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exm_rd = 5'd5; bus.exm_reg_write = 1'b1; bus.exm_result = 32'h11;
    bus.mwb_rd = 5'd5; bus.mwb_reg_write = 1'b1; bus.mwb_result = 32'h22;
    #1;
    chk("fwd_exm_wins", bus.alu_op1, 32'h11);
    bus.exm_reg_write = 1'b0;
    #1;
    chk("fwd_mwb", bus.alu_op1, 32'h22);
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd0; bus.in_rs1_data = 32'h77;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exm_rd = 5'd0; bus.exm_reg_write = 1'b1; bus.exm_result = 32'h11;
    bus.mwb_rd = 5'd0; bus.mwb_reg_write = 1'b1; bus.mwb_result = 32'h22;
    #1;
    chk("fwd_x0_zero", bus.alu_op1, 32'd0);

    // Load-use bubble, then no stall when rs2 is not read
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_rd = 5'd7;
    bus.in_mem_read = 1'b1; bus.in_reg_write = 1'b1;
    tick();
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd2; bus.in_rs2 = 5'd7; bus.in_uses_rs2 = 1'b1;
    bus.in_rd = 5'd8; bus.in_reg_write = 1'b1;
    #1;
    chk("lu_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("lu_bubble_mem_read", {31'b0, bus.out_mem_read}, 32'd0);
    chk("lu_bubble_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    chk("lu_retry_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("lu_add_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("lu_add_rd", {27'b0, bus.out_rd}, 32'd8);
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_rd = 5'd7;
    bus.in_mem_read = 1'b1; bus.in_reg_write = 1'b1;
    tick();
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd2; bus.in_rs2 = 5'd7; bus.in_uses_rs2 = 1'b0;
    bus.in_rd = 5'd8; bus.in_reg_write = 1'b1;
    #1;
    chk("nolu_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("nolu_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("nolu_rd", {27'b0, bus.out_rd}, 32'd8);

    // Hold refresh keeps a value forwarded only in the first held cycle
    clear_in();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd3; bus.in_rs1_data = 32'h1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.mwb_rd = 5'd3; bus.mwb_reg_write = 1'b1; bus.mwb_result = 32'hABCD;
    #1;
    chk("hold_c1", bus.alu_op1, 32'hABCD);
    tick();
    bus.mwb_rd = 5'd0; bus.mwb_reg_write = 1'b0; bus.mwb_result = 32'h0;
    #1;
    chk("hold_c2", bus.alu_op1, 32'hABCD);
    chk("hold_c2_valid", {31'b0, bus.out_valid}, 32'd1);
    tick();
    chk("hold_c3", bus.alu_op1, 32'hABCD);
    bus.out_ready = 1'b1;
    tick();
    chk("hold_drained", {31'b0, bus.out_valid}, 32'd0);

    // Flush drops both the held and the incoming instruction
    clear_in();
    bus.in_valid = 1'b1; bus.in_rd = 5'd4; bus.in_reg_write = 1'b1;
    tick();
    bus.in_rd = 5'd6; bus.out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_reg_write", {31'b0, bus.out_reg_write}, 32'd0);

    // Source muxing: pc/imm selected, store data still forwarded
    clear_in();
    bus.in_valid = 1'b1; bus.in_op1_pc = 1'b1; bus.in_pc = 32'h100;
    bus.in_alu_src = 1'b1; bus.in_imm = 32'hFFFF_FFFC; bus.in_rs2 = 5'd6;
    bus.in_uses_rs2 = 1'b1; bus.in_mem_write = 1'b1; bus.in_alu_ctrl = ALU_SLT;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exm_rd = 5'd6; bus.exm_reg_write = 1'b1; bus.exm_result = 32'h55;
    #1;
    chk("mux_op1_pc", bus.alu_op1, 32'h100);
    chk("mux_op2_imm", bus.alu_op2, 32'hFFFF_FFFC);
    chk("mux_store_data", bus.store_data, 32'h55);
    chk("mux_alu_ctrl", {29'b0, bus.alu_ctrl}, 32'd5);
    chk("mux_pc_out", bus.out_pc, 32'h100);

    // Reset while holding discards the entry
    rst_n = 1'b0;
    tick();
    chk("rst_hold_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_hold_mem_write", {31'b0, bus.out_mem_write}, 32'd0);
    chk("rst_hold_op1", bus.alu_op1, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
